// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control unit: opcodes, IR field positions,
// FSM state encoding and the instruction-class decode used to pick an execute path.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned FIELD_W = 4;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_T0     = 4'd0,
    S_T1     = 4'd1,
    S_T2     = 4'd2,
    S_T3     = 4'd3,
    S_T4     = 4'd4,
    S_T5     = 4'd5,
    S_T6     = 4'd6,
    S_HALTED = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_RFMT,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_HALT
  } iclass_e;

  // Unlisted opcodes fall into CLS_NOP so they retire straight after fetch.
  function automatic iclass_e classify(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  return CLS_RFMT;
      OP_NEG, OP_NOT:                   return CLS_UNARY;
      OP_MUL, OP_DIV:                   return CLS_MULDIV;
      OP_HALT:                          return CLS_HALT;
      default:                          return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-to-N one-hot register select decoder with enable; all outputs low when disabled.
module reg_sel_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [FIELD_W-1:0]  sel_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot_o[i] = en_i && (32'(sel_i) == i);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2 then class-specific execute steps,
// producing one-hot datapath strobes from the current state and IR fields.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OPC_W    = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                PCout,
  output logic                IncPC,
  output logic                MARin,
  output logic                memRead,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIin,
  output logic                LOin,
  output logic [OPC_W-1:0]    alu_op,
  output logic                run,
  output logic [3:0]          state_dbg
);

  state_e  state_q, state_d;
  iclass_e class_q, class_d;

  logic [4:0]         opc;
  logic [FIELD_W-1:0] ra, rb, rc;
  logic [FIELD_W-1:0] ro_sel, ri_sel;
  logic               ro_en, ri_en;
  logic               unused_ir_bits;

  assign opc            = ir[OPC_MSB -: 5];
  assign ra             = ir[RA_MSB -: FIELD_W];
  assign rb             = ir[RB_MSB -: FIELD_W];
  assign rc             = ir[RC_MSB -: FIELD_W];
  assign unused_ir_bits = ^ir[RC_MSB-FIELD_W:0];
  assign state_dbg      = state_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_T0;
      class_q <= CLS_NOP;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // The instruction class is latched when leaving T2 so later IR changes
  // cannot redirect an execute sequence already under way.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_T0: state_d = S_T1;
      S_T1: if (mem_ready) state_d = S_T2;
      S_T2: begin
        class_d = classify(opc);
        case (class_d)
          CLS_NOP:  state_d = S_T0;
          CLS_HALT: state_d = S_HALTED;
          default:  state_d = S_T3;
        endcase
      end
      S_T3:     state_d = S_T4;
      S_T4:     state_d = (class_q == CLS_UNARY) ? S_T0 : S_T5;
      S_T5:     state_d = (class_q == CLS_MULDIV) ? S_T6 : S_T0;
      S_T6:     state_d = S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_T0;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    memRead  = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    alu_op   = '0;
    run      = 1'b1;
    ro_en    = 1'b0;
    ro_sel   = '0;
    ri_en    = 1'b0;
    ri_sel   = '0;
    // Strobes are forced low for the whole time reset is held.
    if (clear) begin
      case (state_q)
        S_T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
        end
        S_T1: begin
          memRead = 1'b1;
          MDRin   = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        S_T3: begin
          case (class_q)
            CLS_RFMT: begin
              ro_en  = 1'b1;
              ro_sel = rb;
              Yin    = 1'b1;
            end
            CLS_UNARY: begin
              ro_en  = 1'b1;
              ro_sel = rb;
              Zin    = 1'b1;
              alu_op = opc;
            end
            CLS_MULDIV: begin
              ro_en  = 1'b1;
              ro_sel = ra;
              Yin    = 1'b1;
            end
            default: ;
          endcase
        end
        S_T4: begin
          case (class_q)
            CLS_RFMT: begin
              ro_en  = 1'b1;
              ro_sel = rc;
              Zin    = 1'b1;
              alu_op = opc;
            end
            CLS_UNARY: begin
              Zlowout = 1'b1;
              ri_en   = 1'b1;
              ri_sel  = ra;
            end
            CLS_MULDIV: begin
              ro_en  = 1'b1;
              ro_sel = rb;
              Zin    = 1'b1;
              alu_op = opc;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (class_q)
            CLS_RFMT: begin
              Zlowout = 1'b1;
              ri_en   = 1'b1;
              ri_sel  = ra;
            end
            CLS_MULDIV: begin
              Zlowout = 1'b1;
              LOin    = 1'b1;
            end
            default: ;
          endcase
        end
        S_T6: begin
          if (class_q == CLS_MULDIV) begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
          end
        end
        S_HALTED: run = 1'b0;
        default: ;
      endcase
    end
  end

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_out_dec (
    .sel_i    (ro_sel),
    .en_i     (ro_en),
    .onehot_o (reg_out)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_in_dec (
    .sel_i    (ri_sel),
    .en_i     (ri_en),
    .onehot_o (reg_in)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/execute sequences cycle by
// cycle and checks state, strobes, register selects, alu_op and run.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b1;
  logic [15:0] reg_out, reg_in;
  logic        PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin;
  logic [4:0]  alu_op;
  logic        run;
  logic [3:0]  state_dbg;
  logic [12:0] strb;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [12:0] B_PCOUT = 13'h1000, B_INCPC = 13'h0800, B_MARIN = 13'h0400,
                          B_MEMRD = 13'h0200, B_MDRIN = 13'h0100, B_MDROUT = 13'h0080,
                          B_IRIN  = 13'h0040, B_YIN   = 13'h0020, B_ZIN    = 13'h0010,
                          B_ZHI   = 13'h0008, B_ZLO   = 13'h0004, B_HIIN   = 13'h0002,
                          B_LOIN  = 13'h0001;
  localparam logic [12:0] ST_T0 = B_PCOUT | B_INCPC | B_MARIN;
  localparam logic [12:0] ST_T1 = B_MEMRD | B_MDRIN;
  localparam logic [12:0] ST_T2 = B_MDROUT | B_IRIN;

  localparam logic [31:0] IR_NOT  = 32'h9338_0000;
  localparam logic [31:0] IR_ADD  = 32'h191A_0000;
  localparam logic [31:0] IR_MUL  = 32'h8188_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_UNK  = 32'h0000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  assign strb = {PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
                 Yin, Zin, Zhighout, Zlowout, HIin, LOin};

  control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .clock     (clock),
    .clear     (clear),
    .ir        (ir),
    .mem_ready (mem_ready),
    .reg_out   (reg_out),
    .reg_in    (reg_in),
    .PCout     (PCout),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .memRead   (memRead),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .Zhighout  (Zhighout),
    .Zlowout   (Zlowout),
    .HIin      (HIin),
    .LOin      (LOin),
    .alu_op    (alu_op),
    .run       (run),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [12:0] s,
                         input logic [15:0] ro, input logic [15:0] ri,
                         input logic [4:0] alu, input logic rn);
    chk({tag, ".state"},   32'(state_dbg), 32'(st));
    chk({tag, ".strobes"}, 32'(strb),      32'(s));
    chk({tag, ".reg_out"}, 32'(reg_out),   32'(ro));
    chk({tag, ".reg_in"},  32'(reg_in),    32'(ri));
    chk({tag, ".alu_op"},  32'(alu_op),    32'(alu));
    chk({tag, ".run"},     32'(run),       32'(rn));
  endtask

  // Check at 1 time unit after a falling edge, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [12:0] s,
                     input logic [15:0] ro, input logic [15:0] ri,
                     input logic [4:0] alu, input logic rn);
    #1;
    chk_all(tag, st, s, ro, ri, alu, rn);
    @(negedge clock);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".t0"}, 4'd0, ST_T0, '0, '0, '0, 1'b1);
    cyc({tag, ".t1"}, 4'd1, ST_T1, '0, '0, '0, 1'b1);
    cyc({tag, ".t2"}, 4'd2, ST_T2, '0, '0, '0, 1'b1);
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    cyc("reset", 4'd0, '0, '0, '0, '0, 1'b1);

    // NOT R6,R7
    ir    = IR_NOT;
    clear = 1'b1;
    fetch("not");
    cyc("not.t3", 4'd3, B_ZIN, 16'h0080, '0, 5'h12, 1'b1);
    cyc("not.t4", 4'd4, B_ZLO, '0, 16'h0040, '0, 1'b1);

    // ADD R2,R3,R4 (its T0 also confirms NOT returned at cycle 5)
    ir = IR_ADD;
    fetch("add");
    cyc("add.t3", 4'd3, B_YIN, 16'h0008, '0, '0, 1'b1);
    cyc("add.t4", 4'd4, B_ZIN, 16'h0010, '0, 5'h03, 1'b1);
    cyc("add.t5", 4'd5, B_ZLO, '0, 16'h0004, '0, 1'b1);

    // MUL R3,R1
    ir = IR_MUL;
    fetch("mul");
    cyc("mul.t3", 4'd3, B_YIN, 16'h0008, '0, '0, 1'b1);
    cyc("mul.t4", 4'd4, B_ZIN, 16'h0002, '0, 5'h10, 1'b1);
    cyc("mul.t5", 4'd5, B_ZLO | B_LOIN, '0, '0, '0, 1'b1);
    cyc("mul.t6", 4'd6, B_ZHI | B_HIIN, '0, '0, '0, 1'b1);

    // NOP with memory wait: T1 held for 4 cycles
    ir        = IR_NOP;
    mem_ready = 1'b0;
    cyc("wait.t0", 4'd0, ST_T0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      cyc($sformatf("wait.t1_%0d", i), 4'd1, ST_T1, '0, '0, '0, 1'b1);
    end
    cyc("wait.t2", 4'd2, ST_T2, '0, '0, '0, 1'b1);

    // Unknown opcode 00000 behaves as NOP: T2 -> T0
    ir = IR_UNK;
    fetch("unk");

    // ADD interrupted by reset in T4
    ir = IR_ADD;
    fetch("addclr");
    cyc("addclr.t3", 4'd3, B_YIN, 16'h0008, '0, '0, 1'b1);
    #1;
    chk_all("addclr.t4", 4'd4, B_ZIN, 16'h0010, '0, 5'h03, 1'b1);
    #1;
    clear = 1'b0;
    #1;
    chk_all("addclr.async", 4'd0, '0, '0, '0, '0, 1'b1);
    @(negedge clock);
    clear = 1'b1;
    fetch("restart");
    cyc("restart.t3", 4'd3, B_YIN, 16'h0008, '0, '0, 1'b1);
    cyc("restart.t4", 4'd4, B_ZIN, 16'h0010, '0, 5'h03, 1'b1);
    cyc("restart.t5", 4'd5, B_ZLO, '0, 16'h0004, '0, 1'b1);

    // HALT and exit by reset
    ir = IR_HALT;
    fetch("halt");
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("halt.h%0d", i), 4'd15, '0, '0, '0, '0, 1'b0);
    end
    #2;
    clear = 1'b0;
    #1;
    chk_all("halt.clr", 4'd0, '0, '0, '0, '0, 1'b1);
    @(negedge clock);
    clear = 1'b1;
    cyc("halt.resume", 4'd0, ST_T0, '0, '0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
